// File: rtl/regfile_bypass.sv
// regfile_bypass
//   Parametrised register file for the MIPS datapath: two registered read
//   ports (decode side), one write port (writeback side), same-cycle
//   write-to-read bypass, optional hardwired-zero entry 0, asynchronous reset
//   of the whole array and a sequenced bulk-clear engine.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   wr_en        write strobe (honoured in IDLE only)
//   wr_addr      write address
//   wr_data      write data
//   rd_addr_a/b  read addresses, sampled every cycle
//   rd_data_a/b  registered read data, one cycle after the address
//   clear_req    single-cycle request to zero the whole array
//   busy         high while the clear sweep runs
//   clear_done   one-cycle pulse on the edge the sweep finishes
//   dbgState     current FSM state (0 = IDLE, 1 = CLEAR)
//
// Clear handshake: clear_req is a one-cycle request that is accepted only
// while busy is low; busy rises on the edge after acceptance, stays high for
// exactly DEPTH cycles, and falls on the same edge that raises clear_done for
// one cycle. A request presented while clear_done is high starts a new sweep.
module regfile_bypass #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter bit ZERO_REG   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  clear_done,
   output logic                  dbgState
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } stateE;

   stateE                 state;
   stateE                 nextState;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  wrAct;
   logic                  sweepLast;
   logic [DATA_WIDTH-1:0] nextRdA;
   logic [DATA_WIDTH-1:0] nextRdB;

   // A write only lands in IDLE, and never on the hardwired-zero entry.
   assign wrAct     = wr_en && (state == IDLE) && !(ZERO_REG && (wr_addr == '0));
   // cnt spans the full address range, so all-ones marks the final entry.
   assign sweepLast = (state == CLEAR) && (&cnt);

   assign busy     = (state == CLEAR);
   assign dbgState = state;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (clear_req) nextState = CLEAR;
         CLEAR:   if (sweepLast) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Sweep counter and completion pulse. cnt wraps naturally to 0 after
   // the last entry, which is also where it must sit in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= sweepLast;
         if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

   // Storage array with asynchronous reset of every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (state == CLEAR) begin
         mem[cnt] <= '0;
      end else if (wrAct) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read data selection: write-first bypass, then zero forcing for the
   // hardwired entry and for the whole sweep.
   always_comb begin
      nextRdA = mem[rd_addr_a];
      nextRdB = mem[rd_addr_b];
      if (wrAct && (rd_addr_a == wr_addr)) nextRdA = wr_data;
      if (wrAct && (rd_addr_b == wr_addr)) nextRdB = wr_data;
      if ((state == CLEAR) || (ZERO_REG && (rd_addr_a == '0))) nextRdA = '0;
      if ((state == CLEAR) || (ZERO_REG && (rd_addr_b == '0))) nextRdB = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         rd_data_a <= nextRdA;
         rd_data_b <= nextRdB;
      end
   end

endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass
//   Three instances driven side by side: default (32x16, no zero register),
//   the same geometry with ZERO_REG=1 sharing its inputs, and an 8-bit by
//   32-entry instance with its own inputs. Each is compared every cycle to
//   a behavioural model of the register file.
module tb_regfile_bypass;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- DUT signals ----------------
   logic        wr_en, clear_req;
   logic [3:0]  wr_addr, rd_addr_a, rd_addr_b;
   logic [31:0] wr_data;
   logic [31:0] rdA0, rdB0, rdAZ, rdBZ;
   logic        busy0, done0, busyZ, doneZ, dbg0, dbgZ;

   logic        wrEnW, clearReqW;
   logic [4:0]  wrAddrW, rdAddrAW, rdAddrBW;
   logic [7:0]  wrDataW, rdAW, rdBW;
   logic        busyW, doneW, dbgW;

   regfile_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rdA0), .rd_data_b(rdB0),
      .clear_req(clear_req), .busy(busy0), .clear_done(done0), .dbgState(dbg0));

   regfile_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1'b1)) dutZ (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rdAZ), .rd_data_b(rdBZ),
      .clear_req(clear_req), .busy(busyZ), .clear_done(doneZ), .dbgState(dbgZ));

   regfile_bypass #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .ZERO_REG(1'b0)) dutW (
      .clk(clk), .rst_n(rst_n), .wr_en(wrEnW), .wr_addr(wrAddrW), .wr_data(wrDataW),
      .rd_addr_a(rdAddrAW), .rd_addr_b(rdAddrBW), .rd_data_a(rdAW), .rd_data_b(rdBW),
      .clear_req(clearReqW), .busy(busyW), .clear_done(doneW), .dbgState(dbgW));

   // ---------------- scoreboard / reference model ----------------
   int nChecks = 0;
   int nPass   = 0;

   logic [31:0] refMem  [3][32];
   int          sweepPos[3];      // entry being wiped this cycle, -1 when idle
   logic [31:0] expA    [3];
   logic [31:0] expB    [3];
   logic        expBusy [3];
   logic        expDone [3];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) begin
         nPass++;
      end else begin
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 32; i++) refMem[k][i] = '0;
         sweepPos[k] = -1;
         expA[k] = '0;
         expB[k] = '0;
         expBusy[k] = 1'b0;
         expDone[k] = 1'b0;
      end
   endtask

   // One rising edge of instance k, given the inputs it saw at that edge.
   task automatic modelStep(input int k, input int depth, input bit zr, input logic [31:0] mask,
                            input bit wen, input int wa, input logic [31:0] wd,
                            input int ra, input int rb, input bit creq);
      bit doWrite;
      if (sweepPos[k] >= 0) begin
         refMem[k][sweepPos[k]] = '0;
         expA[k] = '0;
         expB[k] = '0;
         expDone[k] = (sweepPos[k] == depth - 1);
         sweepPos[k] = (sweepPos[k] == depth - 1) ? -1 : sweepPos[k] + 1;
      end else begin
         expDone[k] = 1'b0;
         doWrite = wen && !(zr && wa == 0);
         expA[k] = (zr && ra == 0) ? 32'h0 : (doWrite && ra == wa) ? (wd & mask) : refMem[k][ra];
         expB[k] = (zr && rb == 0) ? 32'h0 : (doWrite && rb == wa) ? (wd & mask) : refMem[k][rb];
         if (doWrite) refMem[k][wa] = wd & mask;
         if (creq) sweepPos[k] = 0;
      end
      expBusy[k] = (sweepPos[k] >= 0);
   endtask

   task automatic checkInst(input string tag, input int k, input logic [31:0] a, input logic [31:0] b,
                            input logic bz, input logic dn);
      chk({tag, " rdA"}, a, expA[k]);
      chk({tag, " rdB"}, b, expB[k]);
      chk({tag, " busy"}, {31'b0, bz}, {31'b0, expBusy[k]});
      chk({tag, " done"}, {31'b0, dn}, {31'b0, expDone[k]});
   endtask

   task automatic checkAll();
      checkInst("d0", 0, rdA0, rdB0, busy0, done0);
      checkInst("dZ", 1, rdAZ, rdBZ, busyZ, doneZ);
      checkInst("dW", 2, {24'b0, rdAW}, {24'b0, rdBW}, busyW, doneW);
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      modelStep(0, 16, 1'b0, 32'hFFFF_FFFF, wr_en, int'(wr_addr), wr_data,
                int'(rd_addr_a), int'(rd_addr_b), clear_req);
      modelStep(1, 16, 1'b1, 32'hFFFF_FFFF, wr_en, int'(wr_addr), wr_data,
                int'(rd_addr_a), int'(rd_addr_b), clear_req);
      modelStep(2, 32, 1'b0, 32'h0000_00FF, wrEnW, int'(wrAddrW), {24'b0, wrDataW},
                int'(rdAddrAW), int'(rdAddrBW), clearReqW);
      #1;
      checkAll();
   endtask

   task automatic drive(input bit wen, input int wa, input logic [31:0] wd,
                        input int ra, input int rb, input bit creq);
      wr_en     = wen;
      wr_addr   = 4'(wa);
      wr_data   = wd;
      rd_addr_a = 4'(ra);
      rd_addr_b = 4'(rb);
      clear_req = creq;
   endtask

   task automatic driveW(input bit wen, input int wa, input logic [7:0] wd,
                         input int ra, input int rb, input bit creq);
      wrEnW     = wen;
      wrAddrW   = 5'(wa);
      wrDataW   = wd;
      rdAddrAW  = 5'(ra);
      rdAddrBW  = 5'(rb);
      clearReqW = creq;
   endtask

   task automatic asyncReset();
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkAll();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   int busyCnt;
   int doneCnt;
   bit seen;

   initial begin
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      driveW(0, 0, 8'h00, 0, 0, 0);
      modelReset();
      #3;
      rst_n = 1'b0;
      #1;
      checkAll();
      @(negedge clk);
      rst_n = 1'b1;

      // Basic write then read
      drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0);
      tick();
      drive(0, 0, 0, 5, 6, 0);
      tick();
      chk("basic rdA", rdA0, 32'hDEAD_BEEF);
      chk("basic rdB", rdB0, 32'h0);

      // Same-cycle bypass on both ports
      drive(1, 3, 32'h1234_5678, 3, 3, 0);
      tick();
      chk("bypass rdA", rdA0, 32'h1234_5678);
      chk("bypass rdB", rdB0, 32'h1234_5678);

      // Entry 0: plain storage vs hardwired zero
      drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
      tick();
      chk("zero0 bypass", rdA0, 32'hFFFF_FFFF);
      chk("zeroZ bypass", rdAZ, 32'h0);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("zero0 later", rdB0, 32'hFFFF_FFFF);
      chk("zeroZ later", rdBZ, 32'h0);

      // Fill all entries, then sweep with ignored writes/requests
      for (int i = 0; i < 16; i++) begin
         drive(1, i, 32'(i + 1), $urandom_range(0, 15), $urandom_range(0, 15), 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 1);
      tick();
      busyCnt = busy0 ? 1 : 0;
      doneCnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (c < 10) drive(1, $urandom_range(0, 15), $urandom, $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 1) == 1);
         else drive(0, 0, 0, $urandom_range(0, 15), $urandom_range(0, 15), 0);
         tick();
         if (busy0) busyCnt++;
         if (done0) doneCnt++;
      end
      chk("sweep busy cycles", 32'(busyCnt), 32'd16);
      chk("sweep done pulses", 32'(doneCnt), 32'd1);
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 0, i, 15 - i, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();

      // Back-to-back: request while clear_done is high
      drive(0, 0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         tick();
         if (done0) seen = 1'b1;
      end
      chk("b2b done seen", {31'b0, seen}, 32'd1);
      drive(0, 0, 0, 0, 0, 1);
      tick();
      chk("b2b busy again", {31'b0, busy0}, 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 20; c++) tick();

      // Reset mid-sweep
      drive(1, 9, 32'h0BAD_0BAD, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 9, 9, 0);
      for (int c = 0; c < 7; c++) tick();
      asyncReset();
      chk("rst busy", {31'b0, busy0}, 32'd0);
      chk("rst done", {31'b0, done0}, 32'd0);
      drive(1, 9, 32'hCAFE_F00D, 9, 0, 0);
      tick();
      chk("post-rst done", {31'b0, done0}, 32'd0);
      drive(0, 0, 0, 9, 9, 0);
      tick();
      chk("post-rst rdA", rdA0, 32'hCAFE_F00D);

      // Narrow/deep instance
      driveW(1, 31, 8'hA5, 0, 0, 0);
      tick();
      driveW(0, 0, 8'h00, 31, 31, 0);
      tick();
      chk("wide rdA", {24'b0, rdAW}, 32'h0000_00A5);
      driveW(0, 0, 8'h00, 31, 31, 1);
      tick();
      driveW(0, 0, 8'h00, 31, 31, 0);
      busyCnt = busyW ? 1 : 0;
      doneCnt = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (busyW) busyCnt++;
         if (doneW) doneCnt++;
      end
      chk("wide busy cycles", 32'(busyCnt), 32'd32);
      chk("wide done pulses", 32'(doneCnt), 32'd1);

      // Random traffic on all instances
      for (int c = 0; c < 800; c++) begin
         drive($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom,
               $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 39) == 0);
         driveW($urandom_range(0, 1) == 1, $urandom_range(0, 31), 8'($urandom),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 59) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
